// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared arithmetic definitions for the nibble-serial datapaths.
// Holds the FSM state type and the slice geometry helpers.
package arith_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int slice_count(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/nibble_serial_subtractor_bla4.sv
// 4-bit borrow-lookahead subtract cell: d = a - b - bin.
// Every internal borrow is a flat sum of products of g/p terms.
module bla4
    import arith_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = ~a & b;
    assign p = ~(a ^ b);

    assign c[0] = bin;
    assign c[1] = g[0]
                | (p[0] & bin);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & bin);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & bin);
    assign c[4] = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & bin);

    assign d    = a ^ b ^ c[3:0];
    assign bout = c[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor, one 4-bit slice per cycle,
// LSB first, with valid/ready on both operand and result sides.
module nibble_serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NSLICE = slice_count(WIDTH);
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] d_sl;
    logic               bo_sl;

    // Single shared cell; operands steered by the slice index.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_sl = a_q[i*SLICE_W +: SLICE_W];
                b_sl = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    bla4 u_bla4 (
        .a    (a_sl),
        .b    (b_sl),
        .bin  (brw_q),
        .d    (d_sl),
        .bout (bo_sl)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NSLICE; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        diff_d[i*SLICE_W +: SLICE_W] = d_sl;
                    end
                end
                brw_d = bo_sl;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = DONE;
                    bout_d  = bo_sl;
                    // d_sl[3] is the diff MSB being written this edge.
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1])
                           && (d_sl[SLICE_W-1] != a_q[WIDTH-1]);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor at WIDTH=16.
// Expected values are hand-computed per vector.
module tb_nibble_serial_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    int total;
    int bad;

    nibble_serial_subtractor #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept, wait for result, optionally stall, then hand off.
    task automatic do_op(input string tag,
                         input logic [15:0] av,
                         input logic [15:0] bv,
                         input logic bv_in,
                         input logic [15:0] exp_d,
                         input logic exp_bo,
                         input logic exp_ov,
                         input int hold,
                         input bit junk);
        int lat;
        a        = av;
        b        = bv;
        bin      = bv_in;
        in_valid = 1'b1;
        chk({tag, "_rdy_pre"}, 32'(in_ready), 32'd1);
        tick();
        chk({tag, "_rdy_run"}, 32'(in_ready), 32'd0);
        if (junk) begin
            a   = 16'hDEAD;
            b   = 16'h0BEE;
            bin = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_lat"}, 32'(lat), 32'd4);
        chk({tag, "_diff"}, 32'(diff), 32'(exp_d));
        chk({tag, "_bout"}, 32'(bout), 32'(exp_bo));
        chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ov));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_v"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_d"}, 32'(diff), 32'(exp_d));
            chk({tag, "_hold_b"}, 32'(bout), 32'(exp_bo));
            chk({tag, "_hold_r"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_xfer_v"}, 32'(out_valid), 32'd0);
        chk({tag, "_xfer_r"}, 32'(in_ready), 32'd1);
        chk({tag, "_keep_d"}, 32'(diff), 32'(exp_d));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        tick();
        tick();
        chk("rst_rdy", 32'(in_ready), 32'd1);
        chk("rst_val", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bo", 32'(bout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_rdy", 32'(in_ready), 32'd1);

        do_op("one", 16'h0001, 16'h0000, 1'b0,
              16'h0001, 1'b0, 1'b0, 0, 1'b0);
        do_op("wrap", 16'h0000, 16'h0001, 1'b0,
              16'hFFFF, 1'b1, 1'b0, 0, 1'b0);
        do_op("sovf", 16'h8000, 16'h0001, 1'b0,
              16'h7FFF, 1'b0, 1'b1, 0, 1'b0);
        do_op("eqb", 16'h1234, 16'h1234, 1'b1,
              16'hFFFF, 1'b1, 1'b0, 0, 1'b0);
        do_op("bp", 16'h0000, 16'h0001, 1'b0,
              16'hFFFF, 1'b1, 1'b0, 5, 1'b1);
        do_op("mix", 16'h5A3C, 16'h1234, 1'b0,
              16'h4808, 1'b0, 1'b0, 1, 1'b0);

        // Abort after two slices of 0x8000 - 1.
        a        = 16'h8000;
        b        = 16'h0001;
        bin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid_val", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_rdy", 32'(in_ready), 32'd1);
        chk("abort_val", 32'(out_valid), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bo", 32'(bout), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        do_op("post", 16'h00FF, 16'h0F0F, 1'b0,
              16'hF1F0, 1'b1, 1'b0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
